// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider controller: FSM state encoding,
// minimum legal divide ratio and the ceil(N/2) helper used for the duty split.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Smallest ratio that still yields a full high and a full low phase.
  localparam int DIV_MIN = 2;

  // Number of high cycles in a period of n cycles. Evaluated in int so
  // n = 2^DIV_W-1 cannot overflow.
  function automatic int ceil_half(input int n);
    return (n + 1) >>> 1;
  endfunction

endpackage

// File: rtl/clkdiv_cfg_slot.sv
// Single-entry ratio request slot for clkdiv_ctrl.
//
// Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is high whenever no ratio is pending; the master holds cfg_valid
// and cfg_div stable until that edge. An accepted ratio below DIV_MIN is
// dropped and cfg_err pulses for one cycle after the transfer. A legal ratio
// is either handed straight to the controller (direct=1, apply_now pulses
// combinationally in the transfer cycle) or parked in the pending register
// until the controller asserts consume at a period boundary.
module clkdiv_cfg_slot
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             direct,
  input  logic             consume,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             pend_valid,
  output logic [DIV_W-1:0] pend_div,
  output logic             apply_now
);

  logic             pend_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             err_q;
  logic             accept;
  logic             legal;

  assign accept     = cfg_valid && !pend_q;
  assign legal      = int'(cfg_div) >= DIV_MIN;
  assign apply_now  = accept && legal && direct;
  assign cfg_ready  = !pend_q;
  assign cfg_err    = err_q;
  assign pend_valid = pend_q;
  assign pend_div   = pend_div_q;

  // Pending register and error pulse; consume and accept are exclusive
  // because a request is only accepted while nothing is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (consume) begin
        pend_q <= 1'b0;
      end else if (accept && legal && !direct) begin
        pend_q     <= 1'b1;
        pend_div_q <= cfg_div;
      end
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Glitch-free runtime-programmable clock divider controller.
// Start/stop and ratio changes only take effect at output-period boundaries.
// Optional build macro CLKDIV_CTRL_PERIOD_CNT_EN adds o_period_cnt, a 16-bit
// wrapping count of completed o_clk periods.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_busy,
  output logic [DIV_W-1:0] o_cur_div
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      o_period_cnt
`endif
);

  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_n;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_n;
  logic             at_end;
  logic             consume;
  logic             pend_valid;
  logic [DIV_W-1:0] pend_div;
  logic             apply_now;

  clkdiv_cfg_slot #(
    .DIV_W(DIV_W)
  ) u_slot (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .cfg_valid (i_cfg_valid),
    .cfg_div   (i_cfg_div),
    .direct    (state != RUN),
    .consume   (consume),
    .cfg_ready (o_cfg_ready),
    .cfg_err   (o_cfg_err),
    .pend_valid(pend_valid),
    .pend_div  (pend_div),
    .apply_now (apply_now)
  );

  // Last cycle of the current period.
  assign at_end = (cnt == div - DIV_W'(1));

  // Next-state, next-count and next-ratio selection.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    consume = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (apply_now) div_n = i_cfg_div;
        if (i_en) state_n = RUN;
      end
      RUN: begin
        if (!at_end) begin
          cnt_n = cnt + DIV_W'(1);
        end else begin
          cnt_n = '0;
          if (!i_en) begin
            state_n = STOP;
          end else if (pend_valid) begin
            div_n   = pend_div;
            consume = 1'b1;
          end
        end
      end
      STOP: begin
        cnt_n   = '0;
        state_n = IDLE;
        if (pend_valid) begin
          div_n   = pend_div;
          consume = 1'b1;
        end else if (apply_now) begin
          div_n = i_cfg_div;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // FSM, counter, ratio and registered waveform outputs. o_clk/o_tick are
  // derived from the next-state values so they line up with cnt.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      div    <= DIV_W'(DEFAULT_DIV);
      o_clk  <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      div    <= div_n;
      o_clk  <= (state_n == RUN) && (int'(cnt_n) < ceil_half(int'(div_n)));
      o_tick <= (state_n == RUN) && (cnt_n == '0);
    end
  end

  assign o_busy    = (state != IDLE);
  assign o_cur_div = div;

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;

  // Completed-period counter: bumps at every RUN boundary, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      period_cnt <= '0;
    end else if (state == RUN && at_end) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  assign o_period_cnt = period_cnt;
`else
  // Period counter not built in this configuration.
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Testbench for clkdiv_ctrl: vector table, directed corner sequences and a
// randomized run, all compared against a period-level reference model.
module tb_clkdiv_ctrl;

  localparam int DIV_W = 8;
  localparam int DEF   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready, cfg_err, dclk, tick, busy;
  logic [DIV_W-1:0] cur_div;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  always #5 clk = ~clk;

  clkdiv_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_cfg_valid(cfg_valid),
    .i_cfg_div  (cfg_div),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err  (cfg_err),
    .o_clk      (dclk),
    .o_tick     (tick),
    .o_busy     (busy),
    .o_cur_div  (cur_div)
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    ,
    .o_period_cnt(period_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Models the divider as "running a period of m_ratio cycles at position
  // m_pos", plus a one-cycle stopping phase and a queue of pending ratios.
  bit m_run = 0, m_stop = 0, m_err = 0, m_accepted = 0;
  int m_pos = 0, m_ratio = DEF, m_pcnt = 0;
  int m_pend[$];

  task automatic model_step(input bit r, input bit e, input bit v, input int d);
    bit acc, ok, was_run;
    if (!r) begin
      m_run = 0; m_stop = 0; m_pos = 0; m_ratio = DEF;
      m_pend.delete(); m_err = 0; m_pcnt = 0; m_accepted = 0;
      return;
    end
    acc     = v && (m_pend.size() == 0);
    ok      = d >= 2;
    was_run = m_run;
    if (m_run) begin
      if (m_pos != m_ratio - 1) begin
        m_pos++;
      end else begin
        m_pcnt = (m_pcnt + 1) % 65536;
        m_pos  = 0;
        if (!e) begin
          m_run = 0; m_stop = 1;
        end else if (m_pend.size() > 0) begin
          m_ratio = m_pend.pop_front();
        end
      end
    end else if (m_stop) begin
      m_stop = 0;
      if (m_pend.size() > 0) m_ratio = m_pend.pop_front();
    end else if (e) begin
      m_run = 1; m_pos = 0;
    end
    if (acc && ok) begin
      if (was_run) m_pend.push_back(d);
      else m_ratio = d;
    end
    m_err      = acc && !ok;
    m_accepted = acc;
  endtask

  task automatic check_model();
    check("model_clk",   16'(dclk),      16'(m_run && (m_pos < (m_ratio + 1) / 2)));
    check("model_tick",  16'(tick),      16'(m_run && m_pos == 0));
    check("model_busy",  16'(busy),      16'(m_run || m_stop));
    check("model_ready", 16'(cfg_ready), 16'(m_pend.size() == 0));
    check("model_err",   16'(cfg_err),   16'(m_err));
    check("model_cur",   16'(cur_div),   16'(m_ratio));
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    check("model_pcnt",  period_cnt,     16'(m_pcnt));
`endif
  endtask

  // ---------------- driver ----------------
  // Drive at negedge, let the DUT and model step at posedge, compare at negedge.
  task automatic cycle(input logic r, input logic e, input logic v, input logic [DIV_W-1:0] d);
    rst_n = r; en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    model_step(r, e, v, int'(d));
    @(negedge clk);
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             r, e, v;
    logic [DIV_W-1:0] d;
    logic             x_clk, x_tick, x_busy, x_err;
    logic [DIV_W-1:0] x_cur;
  } vec_t;

  vec_t vecs[17];

  task automatic set_vec(input int i, input logic r, input logic e, input logic v,
                         input logic [DIV_W-1:0] d, input logic xc, input logic xt,
                         input logic xb, input logic xe, input logic [DIV_W-1:0] xd);
    vecs[i].r = r; vecs[i].e = e; vecs[i].v = v; vecs[i].d = d;
    vecs[i].x_clk = xc; vecs[i].x_tick = xt; vecs[i].x_busy = xb;
    vecs[i].x_err = xe; vecs[i].x_cur = xd;
  endtask

  logic [4:0] pat;

  initial begin
    //          r  e  v  d   clk tick busy err cur
    set_vec(0,  0, 1, 0, 0,  0,  0,   0,   0,  4);  // reset
    set_vec(1,  1, 1, 0, 0,  1,  1,   1,   0,  4);  // first RUN cycle
    set_vec(2,  1, 1, 0, 0,  1,  0,   1,   0,  4);
    set_vec(3,  1, 1, 0, 0,  0,  0,   1,   0,  4);
    set_vec(4,  1, 1, 0, 0,  0,  0,   1,   0,  4);
    set_vec(5,  1, 1, 0, 0,  1,  1,   1,   0,  4);  // second period
    set_vec(6,  1, 1, 0, 0,  1,  0,   1,   0,  4);
    set_vec(7,  1, 0, 0, 0,  0,  0,   1,   0,  4);  // en dropped mid-period
    set_vec(8,  1, 0, 0, 0,  0,  0,   1,   0,  4);
    set_vec(9,  1, 0, 0, 0,  0,  0,   1,   0,  4);  // STOP
    set_vec(10, 1, 0, 0, 0,  0,  0,   0,   0,  4);  // IDLE
    set_vec(11, 1, 0, 1, 1,  0,  0,   0,   1,  4);  // N=1 rejected
    set_vec(12, 1, 0, 0, 0,  0,  0,   0,   0,  4);
    set_vec(13, 1, 0, 1, 0,  0,  0,   0,   1,  4);  // N=0 rejected
    set_vec(14, 1, 0, 0, 0,  0,  0,   0,   0,  4);
    set_vec(15, 1, 0, 1, 6,  0,  0,   0,   0,  6);  // legal in IDLE
    set_vec(16, 1, 0, 0, 0,  0,  0,   0,   0,  6);

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d_clk", i),  16'(dclk),      16'(vecs[i].x_clk));
      check($sformatf("vec%0d_tick", i), 16'(tick),      16'(vecs[i].x_tick));
      check($sformatf("vec%0d_busy", i), 16'(busy),      16'(vecs[i].x_busy));
      check($sformatf("vec%0d_rdy", i),  16'(cfg_ready), 16'd1);
      check($sformatf("vec%0d_err", i),  16'(cfg_err),   16'(vecs[i].x_err));
      check($sformatf("vec%0d_cur", i),  16'(cur_div),   16'(vecs[i].x_cur));
    end

    // Ratio change 4 -> 5 requested at cnt=1 of a running period.
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);                       // cnt0
    cycle(1, 1, 0, 0);                       // cnt1
    cycle(1, 1, 1, 5);                       // accepted, now cnt2
    check("chg_ready_cnt2", 16'(cfg_ready), 16'd0);
    cycle(1, 1, 0, 0);                       // cnt3
    check("chg_ready_cnt3", 16'(cfg_ready), 16'd0);
    check("chg_cur_old",    16'(cur_div),   16'd4);
    check("chg_clk_old",    16'(dclk),      16'd0);
    cycle(1, 1, 0, 0);                       // first cnt0 at N=5
    check("chg_cur_new",    16'(cur_div),   16'd5);
    check("chg_ready_back", 16'(cfg_ready), 16'd1);
    check("chg_tick_new",   16'(tick),      16'd1);
    pat = 5'b11100;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("chg_wave%0d", k), 16'(dclk), 16'(pat[4 - (k % 5)]));
      cycle(1, 1, 0, 0);
    end

    // N=3, en dropped in the cnt=0 cycle: period completes, then STOP, IDLE.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 3);
    check("stop_cur3", 16'(cur_div), 16'd3);
    cycle(1, 1, 0, 0);
    check("stop_cnt0_clk", 16'(dclk), 16'd1);
    cycle(1, 0, 0, 0);
    check("stop_cnt1_clk", 16'(dclk), 16'd1);
    cycle(1, 0, 0, 0);
    check("stop_cnt2_clk", 16'(dclk), 16'd0);
    check("stop_cnt2_busy", 16'(busy), 16'd1);
    cycle(1, 0, 0, 0);
    check("stop_state_busy", 16'(busy), 16'd1);
    check("stop_state_clk",  16'(dclk), 16'd0);
    cycle(1, 0, 0, 0);
    check("idle_busy", 16'(busy), 16'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, 0);
      check("idle_clk_low", 16'(dclk), 16'd0);
    end

    // Sync reset mid-period (N=7, cnt=2) with a ratio pending.
    cycle(1, 0, 1, 7);
    cycle(1, 1, 0, 0);                       // cnt0
    cycle(1, 1, 0, 0);                       // cnt1
    cycle(1, 1, 1, 9);                       // cnt2, 9 pending
    check("rst_pre_ready", 16'(cfg_ready), 16'd0);
    check("rst_pre_clk",   16'(dclk),      16'd1);
    cycle(0, 1, 0, 0);
    check("rst_clk",   16'(dclk),      16'd0);
    check("rst_cur",   16'(cur_div),   16'(DEF));
    check("rst_ready", 16'(cfg_ready), 16'd1);
    check("rst_busy",  16'(busy),      16'd0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst_cur_hold", 16'(cur_div), 16'(DEF));

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    // N=2 for 20 running cycles -> 10 completed periods, held once stopped.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 2);
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 19; k++) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("pcnt_10", period_cnt, 16'd10);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0);
    check("pcnt_hold", period_cnt, 16'd10);
`endif

    // Randomized run: master holds each request until the model sees it taken.
    begin
      logic             r_en = 1'b0;
      logic             req = 1'b0;
      logic [DIV_W-1:0] req_div = '0;
      logic             r_rst;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 99) < 6) r_en = ~r_en;
        if (!req && $urandom_range(0, 99) < 15) begin
          req = 1'b1;
          req_div = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 255))
                                                : DIV_W'($urandom_range(0, 9));
        end
        r_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        cycle(r_rst, r_en, req, req ? req_div : DIV_W'(0));
        if (m_accepted) req = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
- Runtime-programmable, glitch-free clock-divider controller: generates divided clock o_clk from i_clk with a divide ratio that can be reconfigured on the fly.
- Start/stop requests and ratio changes are sequenced so they only take effect at output-period boundaries; no runt pulses, no truncated periods.
- Sits between a configuration master (register block or sequencer) and clocked consumers of o_clk/o_tick.

Parameters:
- DIV_W, 8, width of divide-ratio field; legal ratio 2..2^DIV_W-1.
- DEFAULT_DIV, 4, ratio loaded at reset; must be in 2..2^DIV_W-1.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_en  in  1  level request: 1 = run divider, 0 = stop at next period boundary.
- i_cfg_valid  in  1  new-ratio request valid.
- i_cfg_div  in  DIV_W  requested ratio N.
- o_cfg_ready  out  1  controller can accept a ratio request.
- o_cfg_err  out  1  one-cycle pulse: accepted request had illegal ratio (<2).
- o_clk  out  1  divided clock, registered.
- o_tick  out  1  one-cycle pulse coincident with each o_clk rising edge.
- o_busy  out  1  1 while state is not IDLE.
- o_cur_div  out  DIV_W  ratio currently in effect.

Behaviour:
- Reset (i_rst_n low at a clock edge): state IDLE, cnt=0, active ratio=DEFAULT_DIV, pending flag clear; o_clk=0, o_tick=0, o_busy=0, o_cfg_ready=1, o_cfg_err=0, o_cur_div=DEFAULT_DIV. Reset mid-period aborts immediately; o_clk low the following cycle.
- Waveform for ratio N: period-counter cnt runs 0..N-1; o_clk=1 for cnt < ceil(N/2), else 0. Thus high ceil(N/2), low floor(N/2) cycles. o_tick=1 exactly when cnt==0 in RUN.
- States:
  - IDLE: o_clk=0, cnt held at 0. i_en sampled 1 -> RUN. First RUN cycle (cnt=0, o_clk=1, o_tick=1) appears one cycle after the sampling edge.
  - RUN: cnt increments each cycle. At cnt==N-1 (boundary), in priority order:
    - i_en==0 -> STOP.
    - Else if pending valid -> load pending ratio, clear pending, cnt=0.
    - Else -> cnt=0.
  - STOP: single cycle; o_clk=0, o_busy=1, cnt cleared. Next state IDLE; pending ratio is applied here if present.
- i_en dropping mid-period never shortens the current period. i_en re-asserted before the boundary cancels the stop.
- Config handshake: transfer occurs when i_cfg_valid && o_cfg_ready.
  - o_cfg_ready = !pending.
  - In IDLE a legal request is applied the following cycle; no pending stage.
  - In RUN a legal request is held as pending until the boundary.
  - Only one outstanding request; the master must hold i_cfg_valid until accepted.
  - Requests with i_cfg_div<2 are accepted but discarded; o_cfg_err pulses the cycle after acceptance, and active/pending values are unchanged.
- Simultaneous events:
  - Transfer in the boundary cycle is captured as pending and applies at the next boundary; it is not applied in the same cycle.
  - i_en=0 and pending at the same boundary: stop wins; the ratio is applied in STOP.
- o_cur_div updates in the same cycle the new ratio takes effect, i.e. the first cnt=0 of the new period.
- Widths: cnt is DIV_W bits; ceil(N/2) is computed as (N+1)>>1 in DIV_W+1 bits. No wrap beyond N-1.

Optional Feature:
- Macro: CLKDIV_CTRL_PERIOD_CNT_EN.
- Defined: adds output o_period_cnt [15:0], counting completed o_clk periods (increment at each RUN boundary, wraps 0xFFFF->0), cleared by reset and held in IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package clkdiv_pkg: state enum (IDLE, RUN, STOP), DIV_MIN=2 constant, ceil-half helper function.
- One sub-module clkdiv_cfg_slot: single-entry pending register with valid/ready, legality check, and err pulse.
- The FSM, counter and waveform logic stay in clkdiv_ctrl.

Test Plan:
- Reset, DEFAULT_DIV=4, i_en=1 from cycle 0 -> o_clk 1100 repeating; o_tick every 4 cycles; o_busy=1; o_cur_div=4.
- RUN N=4; cfg N=5 at cnt=1 -> o_cfg_ready=0 until boundary; current period completes (4 cycles); next periods 11100; o_cur_div=5 at first new cnt=0.
- RUN N=3; i_en=0 at cnt=0 -> period 110 completes, one STOP cycle, IDLE, o_busy=0, o_clk stays 0.
- cfg N=1 and N=0 in IDLE -> each accepted; o_cfg_err one-cycle pulse; o_cur_div unchanged.
- Sync reset asserted mid-period (N=7, cnt=2) -> next cycle o_clk=0, o_cur_div=DEFAULT_DIV, pending cleared.
- CLKDIV_CTRL_PERIOD_CNT_EN defined; N=2 for 20 cycles -> o_period_cnt=10; holds after stop.
